// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared state encoding, default sizes and one-hot helpers for ring_arbiter
package ring_arb_pkg;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t GRANT = 1'b1;
  localparam int RA_N = 4;
  localparam int RA_TIMEOUT = 16;
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int n);
    return ((v << 1) | (v >> (n - 1))) & ((32'd1 << n) - 32'd1);
  endfunction
  function automatic int oh2idx(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/ring_prio_select.sv
// ring_prio_select: first set req bit at or above one-hot ptr, wrapping, via a double-width search
module ring_prio_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win
);
  logic [N-1:0] mask;
  logic [2*N-1:0] dbl, lo;
  assign mask = ~(ptr - N'(1));
  assign dbl = {req, req & mask};
  assign lo = dbl & (~dbl + (2*N)'(1));
  assign win = lo[N-1:0] | lo[2*N-1:N];
endmodule

// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin one-hot grant held until done.
// Define RING_ARB_TIMEOUT_EN to revoke grants held longer than TIMEOUT cycles.
module ring_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N = RA_N,
  parameter int TIMEOUT = RA_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout
);
  localparam int IW = $clog2(N);
  state_t state;
  logic [N-1:0] ptr, win;
  logic expire, rel;
  if (N < 2 || N > 32 || TIMEOUT < 2) begin : g_bad
    $error("ring_arbiter: unsupported N or TIMEOUT");
  end
  ring_prio_select #(.N(N)) u_sel (.req(req), .ptr(ptr), .win(win));
  assign rel = state == GRANT && (done || expire);
  assign gnt_valid = |gnt;
  assign gnt_idx = IW'(oh2idx(32'(gnt)));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= {{(N-1){1'b0}}, 1'b1};
    end else if (state == IDLE) begin
      if (|req) begin
        gnt <= win;
        state <= GRANT;
      end
    end else if (rel) begin
      gnt <= '0;
      state <= IDLE;
      ptr <= N'(rotl1(32'(gnt), N));
    end
`ifdef RING_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // cnt holds the 1-based count of cycles the current grant has been visible
  assign expire = state == GRANT && cnt == CW'(TIMEOUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= state == IDLE ? CW'(|req) : rel ? '0 : cnt + CW'(1);
      timeout <= expire && !done;
    end
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter that shares one downstream resource among N requesters. Its rotating priority pointer is a one-hot ring register: it resets to bit 0 and, after each grant, advances one position past the winner. The block sits between the requesting agents and the shared resource. It issues one registered one-hot grant at a time and holds it until the owner signals completion.

## Interface
- N, 4: number of requesters; N >= 2.
- TIMEOUT, 16: maximum cycles a grant may be held. Used only when the timeout feature is compiled in; TIMEOUT >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  N  request vector; bit i high means requester i wants the resource.
- done  input  1  release from the current owner; sampled only in GRANT.
- gnt  output  N  registered one-hot grant; all zero when no owner.
- gnt_valid  output  1  high while any gnt bit is set.
- gnt_idx  output  $clog2(N)  binary index of the owner; 0 when gnt_valid is low.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Internal one-hot pointer ptr[N-1:0]; reset value 1 (bit 0).
- States:
  - IDLE: no owner.
  - GRANT: one owner.
- IDLE, req == 0:
  - Stay in IDLE.
  - ptr unchanged.
- IDLE, req != 0:
  - Winner is the first set req bit at or above the ptr position, searching upward and wrapping from N-1 to 0.
  - Next edge: gnt = one-hot winner, gnt_idx = its index, state = GRANT.
- GRANT, done low:
  - gnt held constant.
  - Changes on req, including the owner dropping its request, are ignored.
- GRANT, done high:
  - Next edge: gnt = 0, state = IDLE.
  - ptr = gnt rotated left by one (winner + 1, wrapping N-1 to 0).
- Ownership is released only by done or by timeout. A new request arriving during GRANT waits.
- done in IDLE is ignored.

## Timing
- Reset values: gnt = 0, gnt_valid = 0, gnt_idx = 0, timeout = 0, state = IDLE, ptr = 1.
- Asserting rst clears all outputs immediately, including mid-grant. There is no completion handshake for the aborted owner.
- Grant latency: req high in IDLE at edge k gives gnt high after edge k+1. Latency is 1 cycle.
- Release: done high at edge k gives gnt low after edge k+1.
- Turnaround: at least one cycle with gnt = 0 between consecutive grants, even under continuous requests.
- done and a new req in the same GRANT cycle: release first. Re-arbitration uses the updated ptr in the following IDLE cycle.
- Fairness: with all N bits requesting continuously, each requester is granted once every N grants.

## Configuration
- RING_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in GRANT and clears in IDLE.
  - If done has not arrived by the TIMEOUT-th cycle of gnt high, the next edge forces gnt = 0 and state = IDLE.
  - ptr advances exactly as for a normal release.
  - timeout pulses high for exactly one cycle, coincident with the first cycle of gnt = 0.
  - If done arrives in that same cycle, it counts as a normal release and timeout stays 0.
- RING_ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - timeout is tied to 0.
  - Grants persist until done.

## Structure
- Package ring_arb_pkg:
  - State typedef (IDLE, GRANT).
  - Default N and TIMEOUT constants.
  - Rotate-left-by-one function for one-hot vectors.
  - One-hot-to-index function.
- Sub-module ring_prio_select: combinational. Takes req and ptr and returns the one-hot winner, implemented as a double-width masked priority search. The arbiter instantiates it once.

## Test plan
All scenarios use N = 4.
- Reset: assert rst mid-simulation → gnt = 4'b0000, gnt_valid = 0, gnt_idx = 0, timeout = 0 immediately. After release, req = 4'b1111 grants 4'b0001 first.
- Full rotation: req = 4'b1111 held, done pulsed two cycles after each grant → grants 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between each.
- Wrap-around: after a grant to 4'b0100 is released (ptr = 4'b1000), req = 4'b0011 → gnt = 4'b0001 and gnt_idx = 0.
- Simultaneous release and request: owner 4'b0010 asserts done while req = 4'b0110 → one idle cycle, then gnt = 4'b0100.
- Timeout (RING_ARB_TIMEOUT_EN, TIMEOUT = 4): req = 4'b0001, done never asserted → gnt high exactly 4 cycles, then gnt = 0 with timeout = 1 for one cycle. With req = 4'b0011 held, the next grant is 4'b0010.
- Reset mid-grant: rst asserted while gnt = 4'b1000 → gnt = 0 asynchronously and ptr = 1. After release, req = 4'b1001 → gnt = 4'b0001.
